// File: rtl/vga_pkg.sv
// VGA mode constants shared by the timing generator and its users.
// Two standard modes plus the sync polarity encoding.
package vga_pkg;

    typedef enum bit {
        POL_NEG = 1'b0,
        POL_POS = 1'b1
    } sync_pol_e;

    // 640x480 @ 60 Hz (25.175 MHz pixel clock)
    localparam int        VGA640_H_DISPLAY = 640;
    localparam int        VGA640_H_FRONT   = 16;
    localparam int        VGA640_H_SYNC    = 96;
    localparam int        VGA640_H_BACK    = 48;
    localparam int        VGA640_V_DISPLAY = 480;
    localparam int        VGA640_V_FRONT   = 10;
    localparam int        VGA640_V_SYNC    = 2;
    localparam int        VGA640_V_BACK    = 33;
    localparam sync_pol_e VGA640_H_POL     = POL_NEG;
    localparam sync_pol_e VGA640_V_POL     = POL_NEG;

    // 800x600 @ 60 Hz (40 MHz pixel clock)
    localparam int        SVGA800_H_DISPLAY = 800;
    localparam int        SVGA800_H_FRONT   = 40;
    localparam int        SVGA800_H_SYNC    = 128;
    localparam int        SVGA800_H_BACK    = 88;
    localparam int        SVGA800_V_DISPLAY = 600;
    localparam int        SVGA800_V_FRONT   = 1;
    localparam int        SVGA800_V_SYNC    = 4;
    localparam int        SVGA800_V_BACK    = 23;
    localparam sync_pol_e SVGA800_H_POL     = POL_POS;
    localparam sync_pol_e SVGA800_V_POL     = POL_POS;

endpackage

// File: rtl/clk_en_div.sv
// Pixel-rate strobe generator: one pix_ce pulse every CLK_DIV clocks while en is high.
// ce_next is the same strobe one clk early, so a consumer can load on the edge that raises pix_ce.
module clk_en_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic ce_next,
    output logic pix_ce
);

    localparam int               CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("clk_en_div: CLK_DIV must be at least 1");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pix_ce_q;

    assign ce_next = en && (cnt_q == CNT_LAST);
    assign pix_ce  = pix_ce_q;

    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            pix_ce_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            pix_ce_q <= ce_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters on a divided strobe and a registered
// decode stage, so every output describes the same pixel one pix_ce after the counters reach it.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = VGA640_H_DISPLAY,
    parameter int H_FRONT   = VGA640_H_FRONT,
    parameter int H_SYNC    = VGA640_H_SYNC,
    parameter int H_BACK    = VGA640_H_BACK,
    parameter int V_DISPLAY = VGA640_V_DISPLAY,
    parameter int V_FRONT   = VGA640_V_FRONT,
    parameter int V_SYNC    = VGA640_V_SYNC,
    parameter int V_BACK    = VGA640_V_BACK,
    parameter bit H_POL     = VGA640_H_POL,
    parameter bit V_POL     = VGA640_V_POL,
    parameter int COORD_W   = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    output logic               pix_ce,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               line_start,
    output logic               frame_start,
    output logic               vblank
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > (2 ** COORD_W) || V_TOTAL > (2 ** COORD_W)) begin : g_bad_coord_w
        $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in COORD_W bits");
    end

    // Window bounds are one bit wider so a zero back porch cannot wrap the sync end.
    localparam logic [COORD_W:0]   H_ACT_END = (COORD_W+1)'(H_DISPLAY);
    localparam logic [COORD_W:0]   HS_START  = (COORD_W+1)'(H_DISPLAY + H_FRONT);
    localparam logic [COORD_W:0]   HS_END    = (COORD_W+1)'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [COORD_W:0]   V_ACT_END = (COORD_W+1)'(V_DISPLAY);
    localparam logic [COORD_W:0]   VS_START  = (COORD_W+1)'(V_DISPLAY + V_FRONT);
    localparam logic [COORD_W:0]   VS_END    = (COORD_W+1)'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [COORD_W-1:0] H_LAST    = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST    = COORD_W'(V_TOTAL - 1);

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               hsync;
        logic               vsync;
        logic               video_on;
        logic               vblank;
        logic               line_start;
        logic               frame_start;
    } pix_out_t;

    localparam pix_out_t IDLE_OUT = '{
        x: '0, y: '0, hsync: ~H_POL, vsync: ~V_POL,
        video_on: 1'b0, vblank: 1'b0, line_start: 1'b0, frame_start: 1'b0
    };

    logic               ce_next;
    logic               prime_q, prime_d;
    logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
    logic [COORD_W-1:0] v_cnt_q, v_cnt_d;
    logic [COORD_W:0]   h_wide, v_wide;
    pix_out_t           pix_dec;
    pix_out_t           out_q, out_d;

    clk_en_div #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .ce_next(ce_next),
        .pix_ce (pix_ce)
    );

    // The first strobe after enable only primes the pipe; counters start moving on the second.
    always_comb begin
        prime_d = prime_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!en) begin
            prime_d = 1'b0;
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (ce_next) begin
            prime_d = 1'b1;
            if (prime_q) begin
                if (h_cnt_q == H_LAST) begin
                    h_cnt_d = '0;
                    v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
                end else begin
                    h_cnt_d = h_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prime_q <= 1'b0;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            prime_q <= prime_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_wide = {1'b0, h_cnt_q};
    assign v_wide = {1'b0, v_cnt_q};

    always_comb begin
        pix_dec.x           = h_cnt_q;
        pix_dec.y           = v_cnt_q;
        pix_dec.hsync       = (h_wide >= HS_START && h_wide < HS_END) ? H_POL : ~H_POL;
        pix_dec.vsync       = (v_wide >= VS_START && v_wide < VS_END) ? V_POL : ~V_POL;
        pix_dec.video_on    = (h_wide < H_ACT_END) && (v_wide < V_ACT_END);
        pix_dec.vblank      = (v_wide >= V_ACT_END);
        pix_dec.line_start  = (h_cnt_q == '0);
        pix_dec.frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    // Markers are cleared between strobes so each pulse lasts exactly the pix_ce clk.
    always_comb begin
        out_d = out_q;
        if (!en) begin
            out_d = IDLE_OUT;
        end else if (ce_next) begin
            out_d = prime_q ? pix_dec : IDLE_OUT;
        end else begin
            out_d.line_start  = 1'b0;
            out_d.frame_start = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= IDLE_OUT;
        end else begin
            out_q <= out_d;
        end
    end

    assign x           = out_q.x;
    assign y           = out_q.y;
    assign hsync       = out_q.hsync;
    assign vsync       = out_q.vsync;
    assign video_on    = out_q.video_on;
    assign vblank      = out_q.vblank;
    assign line_start  = out_q.line_start;
    assign frame_start = out_q.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: three instances (reduced timing at CLK_DIV=4,
// tiny active-high timing at CLK_DIV=1, full 640x480 defaults) checked against hand-computed values.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset;
    logic en_a, en_b, en_c;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    // Instance a: CLK_DIV=4, H 16/4/4/4 (28), V 12/2/2/2 (18), active-low syncs
    logic       pix_ce_a, hsync_a, vsync_a, video_on_a, line_start_a, frame_start_a, vblank_a;
    logic [9:0] x_a, y_a;
    logic [25:0] obs_a;
    assign obs_a = {x_a, y_a, hsync_a, vsync_a, video_on_a, vblank_a, line_start_a, frame_start_a};
    localparam logic [25:0] IDLE_A = {10'd0, 10'd0, 1'b1, 1'b1, 4'b0000};

    vga_timing_gen #(
        .CLK_DIV(4), .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(4), .H_BACK(4),
        .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
        .H_POL(1'b0), .V_POL(1'b0), .COORD_W(10)
    ) dut_a (
        .clk(clk), .reset(reset), .en(en_a), .pix_ce(pix_ce_a),
        .hsync(hsync_a), .vsync(vsync_a), .video_on(video_on_a), .x(x_a), .y(y_a),
        .line_start(line_start_a), .frame_start(frame_start_a), .vblank(vblank_a)
    );

    // Instance b: CLK_DIV=1, H 8/2/2/2 (14), V 4/1/1/1 (7), active-high syncs
    logic       pix_ce_b, hsync_b, vsync_b, video_on_b, line_start_b, frame_start_b, vblank_b;
    logic [3:0] x_b, y_b;
    logic [13:0] obs_b;
    assign obs_b = {x_b, y_b, hsync_b, vsync_b, video_on_b, vblank_b, line_start_b, frame_start_b};
    localparam logic [13:0] IDLE_B = {4'd0, 4'd0, 1'b0, 1'b0, 4'b0000};

    vga_timing_gen #(
        .CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .H_POL(1'b1), .V_POL(1'b1), .COORD_W(4)
    ) dut_b (
        .clk(clk), .reset(reset), .en(en_b), .pix_ce(pix_ce_b),
        .hsync(hsync_b), .vsync(vsync_b), .video_on(video_on_b), .x(x_b), .y(y_b),
        .line_start(line_start_b), .frame_start(frame_start_b), .vblank(vblank_b)
    );

    // Instance c: all defaults (640x480, CLK_DIV=4)
    logic       pix_ce_c, hsync_c, vsync_c, video_on_c, line_start_c, frame_start_c, vblank_c;
    logic [9:0] x_c, y_c;
    logic [25:0] obs_c;
    assign obs_c = {x_c, y_c, hsync_c, vsync_c, video_on_c, vblank_c, line_start_c, frame_start_c};
    localparam logic [25:0] IDLE_C = {10'd0, 10'd0, 1'b1, 1'b1, 4'b0000};

    vga_timing_gen dut_c (
        .clk(clk), .reset(reset), .en(en_c), .pix_ce(pix_ce_c),
        .hsync(hsync_c), .vsync(vsync_c), .video_on(video_on_c), .x(x_c), .y(y_c),
        .line_start(line_start_c), .frame_start(frame_start_c), .vblank(vblank_c)
    );

    // Hand model of instance a: hsync low x 20..23, vsync low y 14..15
    function automatic logic [25:0] exp_a(input int h, input int v);
        logic hs, vs, vo, vb, ls, fs;
        hs = !(h >= 20 && h < 24);
        vs = !(v >= 14 && v < 16);
        vo = (h < 16) && (v < 12);
        vb = (v >= 12);
        ls = (h == 0);
        fs = (h == 0) && (v == 0);
        return {10'(h), 10'(v), hs, vs, vo, vb, ls, fs};
    endfunction

    // Hand model of instance b: hsync high x 10..11, vsync high y 5
    function automatic logic [13:0] exp_b(input int h, input int v);
        logic hs, vs, vo, vb, ls, fs;
        hs = (h >= 10 && h < 12);
        vs = (v == 5);
        vo = (h < 8) && (v < 4);
        vb = (v >= 4);
        ls = (h == 0);
        fs = (h == 0) && (v == 0);
        return {4'(h), 4'(v), hs, vs, vo, vb, ls, fs};
    endfunction

    task automatic wait_ce_a(input int budget, output int n);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!pix_ce_a && n < budget);
        if (!pix_ce_a) begin
            n_total++;
            $display("FAIL wait_ce_a: pix_ce=%b after %0d clks, required 1", pix_ce_a, budget);
        end
    endtask

    task automatic wait_ce_b(input int budget, output int n);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!pix_ce_b && n < budget);
        if (!pix_ce_b) begin
            n_total++;
            $display("FAIL wait_ce_b: pix_ce=%b after %0d clks, required 1", pix_ce_b, budget);
        end
    endtask

    task automatic wait_ce_c(input int budget, output int n);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!pix_ce_c && n < budget);
        if (!pix_ce_c) begin
            n_total++;
            $display("FAIL wait_ce_c: pix_ce=%b after %0d clks, required 1", pix_ce_c, budget);
        end
    endtask

    task automatic test_reset();
        en_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (obs_a !== IDLE_A) $display("FAIL reset_out_a: got %h, required %h", obs_a, IDLE_A);
        else n_pass++;
        n_total++;
        if (pix_ce_a !== 1'b0) $display("FAIL reset_pix_ce_a: got %b, required 0", pix_ce_a);
        else n_pass++;
        n_total++;
        if (obs_b !== IDLE_B) $display("FAIL reset_out_b: got %h, required %h", obs_b, IDLE_B);
        else n_pass++;
        n_total++;
        if (obs_c !== IDLE_C) $display("FAIL reset_out_c: got %h, required %h", obs_c, IDLE_C);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Release with en already high: first pix_ce after 4 clks, (0,0) on the second
    task automatic test_startup_a();
        int n;
        wait_ce_a(20, n);
        n_total++;
        if (n !== 4) $display("FAIL startup_first_ce_a: got %0d clks, required 4", n);
        else n_pass++;
        n_total++;
        if (obs_a !== IDLE_A) $display("FAIL startup_first_out_a: got %h, required %h", obs_a, IDLE_A);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (pix_ce_a !== 1'b0) $display("FAIL pix_ce_width_a: got %b, required 0", pix_ce_a);
        else n_pass++;
        wait_ce_a(20, n);
        n_total++;
        if (n !== 3) $display("FAIL startup_second_ce_a: got %0d clks, required 3", n);
        else n_pass++;
        n_total++;
        if (obs_a !== exp_a(0, 0)) $display("FAIL startup_origin_a: got %h, required %h", obs_a, exp_a(0, 0));
        else n_pass++;
    endtask

    task automatic test_frame_a();
        logic [25:0] exp_q[$];
        logic [25:0] e;
        int n, frame_err, period_err, cnt_vo, cnt_hs, cnt_vs;
        frame_err = 0; period_err = 0; cnt_vo = 0; cnt_hs = 0; cnt_vs = 0;
        for (int v = 0; v < 18; v++)
            for (int h = 0; h < 28; h++)
                exp_q.push_back(exp_a(h, v));
        for (int k = 0; k < 504; k++) begin
            e = exp_q.pop_front();
            if (obs_a !== e) frame_err++;
            if (video_on_a) cnt_vo++;
            if (!hsync_a) cnt_hs++;
            if (!vsync_a) cnt_vs++;
            if (k < 503) begin
                wait_ce_a(8, n);
                if (n != 4) period_err++;
            end
        end
        n_total++;
        if (frame_err !== 0) $display("FAIL frame_pixels_a: got %0d wrong pixels, required 0", frame_err);
        else n_pass++;
        n_total++;
        if (period_err !== 0) $display("FAIL frame_ce_period_a: got %0d bad periods, required 0", period_err);
        else n_pass++;
        n_total++;
        if (cnt_vo !== 192) $display("FAIL frame_video_on_a: got %0d pixels, required 192", cnt_vo);
        else n_pass++;
        n_total++;
        if (cnt_hs !== 72) $display("FAIL frame_hsync_a: got %0d active pixels, required 72", cnt_hs);
        else n_pass++;
        n_total++;
        if (cnt_vs !== 56) $display("FAIL frame_vsync_a: got %0d active pixels, required 56", cnt_vs);
        else n_pass++;
        n_total++;
        if (vblank_a !== 1'b1) $display("FAIL last_pixel_vblank_a: got %b, required 1", vblank_a);
        else n_pass++;
        wait_ce_a(8, n);
        n_total++;
        if (obs_a !== exp_a(0, 0)) $display("FAIL frame_wrap_a: got %h, required %h", obs_a, exp_a(0, 0));
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if ({line_start_a, frame_start_a} !== 2'b00)
            $display("FAIL wrap_pulse_width_a: got %b, required 00", {line_start_a, frame_start_a});
        else n_pass++;
    endtask

    // en dropped at (10,5), held low 50 clks, then restarted
    task automatic test_en_drop_a();
        int n, iter, gap_err;
        iter = 0; gap_err = 0;
        do begin
            wait_ce_a(8, n);
            iter++;
        end while (!(x_a == 10'd10 && y_a == 10'd5) && iter < 600);
        n_total++;
        if (x_a !== 10'd10 || y_a !== 10'd5)
            $display("FAIL reach_drop_point_a: got (%0d,%0d), required (10,5)", x_a, y_a);
        else n_pass++;
        @(negedge clk);
        en_a = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if ({pix_ce_a, obs_a} !== {1'b0, IDLE_A})
            $display("FAIL en_drop_abort_a: got %h, required %h", {pix_ce_a, obs_a}, {1'b0, IDLE_A});
        else n_pass++;
        for (int i = 0; i < 49; i++) begin
            @(posedge clk); #1;
            if ({pix_ce_a, obs_a} !== {1'b0, IDLE_A}) gap_err++;
        end
        n_total++;
        if (gap_err !== 0) $display("FAIL en_gap_idle_a: got %0d active clks, required 0", gap_err);
        else n_pass++;
        @(negedge clk);
        en_a = 1'b1;
        wait_ce_a(20, n);
        n_total++;
        if (n !== 4 || obs_a !== IDLE_A)
            $display("FAIL en_rise_first_ce_a: got %0d clks out %h, required 4 clks out %h", n, obs_a, IDLE_A);
        else n_pass++;
        wait_ce_a(20, n);
        n_total++;
        if (n !== 4 || obs_a !== exp_a(0, 0))
            $display("FAIL en_rise_origin_a: got %0d clks out %h, required 4 clks out %h", n, obs_a, exp_a(0, 0));
        else n_pass++;
    endtask

    task automatic test_small_b();
        logic [13:0] exp_q[$];
        logic [13:0] e;
        int n, ce_err, frame_err, fs_at, cnt_hs, cnt_vs;
        ce_err = 0; frame_err = 0; fs_at = -1; cnt_hs = 0; cnt_vs = 0;
        @(negedge clk);
        en_b = 1'b1;
        wait_ce_b(5, n);
        n_total++;
        if (n !== 1 || obs_b !== IDLE_B)
            $display("FAIL small_first_ce_b: got %0d clks out %h, required 1 clk out %h", n, obs_b, IDLE_B);
        else n_pass++;
        wait_ce_b(5, n);
        n_total++;
        if (n !== 1 || obs_b !== exp_b(0, 0))
            $display("FAIL small_origin_b: got %0d clks out %h, required 1 clk out %h", n, obs_b, exp_b(0, 0));
        else n_pass++;
        for (int k = 1; k <= 98; k++)
            exp_q.push_back(exp_b(k % 14, (k / 14) % 7));
        for (int k = 1; k <= 98; k++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            if (pix_ce_b !== 1'b1) ce_err++;
            if (obs_b !== e) frame_err++;
            if (frame_start_b && fs_at < 0) fs_at = k;
            if (hsync_b) cnt_hs++;
            if (vsync_b) cnt_vs++;
        end
        n_total++;
        if (ce_err !== 0) $display("FAIL small_ce_every_clk_b: got %0d gaps, required 0", ce_err);
        else n_pass++;
        n_total++;
        if (frame_err !== 0) $display("FAIL small_pixels_b: got %0d wrong pixels, required 0", frame_err);
        else n_pass++;
        n_total++;
        if (fs_at !== 98) $display("FAIL small_frame_period_b: got %0d clks, required 98", fs_at);
        else n_pass++;
        n_total++;
        if (cnt_hs !== 14 || cnt_vs !== 14)
            $display("FAIL small_sync_high_b: got hs %0d vs %0d, required 14 14", cnt_hs, cnt_vs);
        else n_pass++;
        @(negedge clk);
        en_b = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if ({pix_ce_b, obs_b} !== {1'b0, IDLE_B})
            $display("FAIL small_en_drop_b: got %h, required %h", {pix_ce_b, obs_b}, {1'b0, IDLE_B});
        else n_pass++;
    endtask

    // One full 640x480 line at default settings
    task automatic test_default_line_c();
        int n, period_err, cnt_hs, cnt_vo, first_hs, last_hs;
        period_err = 0; cnt_hs = 0; cnt_vo = 0; first_hs = -1; last_hs = -1;
        @(negedge clk);
        en_c = 1'b1;
        wait_ce_c(20, n);
        wait_ce_c(20, n);
        n_total++;
        if ({x_c, y_c, line_start_c, frame_start_c, video_on_c} !== {10'd0, 10'd0, 3'b111})
            $display("FAIL default_origin_c: got x %0d y %0d ls %b fs %b vo %b, required 0 0 1 1 1",
                     x_c, y_c, line_start_c, frame_start_c, video_on_c);
        else n_pass++;
        for (int k = 0; k < 800; k++) begin
            if (!hsync_c) begin
                cnt_hs++;
                if (first_hs < 0) first_hs = int'(x_c);
                last_hs = int'(x_c);
            end
            if (video_on_c) cnt_vo++;
            wait_ce_c(8, n);
            if (n != 4) period_err++;
        end
        n_total++;
        if (cnt_hs !== 96 || first_hs !== 656 || last_hs !== 751)
            $display("FAIL default_hsync_c: got %0d pixels from x %0d to %0d, required 96 from 656 to 751",
                     cnt_hs, first_hs, last_hs);
        else n_pass++;
        n_total++;
        if (cnt_vo !== 640) $display("FAIL default_video_on_c: got %0d pixels, required 640", cnt_vo);
        else n_pass++;
        n_total++;
        if (period_err !== 0) $display("FAIL default_ce_period_c: got %0d bad periods, required 0", period_err);
        else n_pass++;
        n_total++;
        if ({x_c, y_c, line_start_c, frame_start_c} !== {10'd0, 10'd1, 2'b10})
            $display("FAIL default_next_line_c: got x %0d y %0d ls %b fs %b, required 0 1 1 0",
                     x_c, y_c, line_start_c, frame_start_c);
        else n_pass++;
    endtask

    // Reset mid-line between clock edges, held for 3 clks, released with en still high
    task automatic test_reset_midline();
        int n, iter, hold_err;
        iter = 0; hold_err = 0;
        do begin
            wait_ce_a(8, n);
            iter++;
        end while (!(x_a == 10'd5 && y_a == 10'd0) && iter < 600);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        n_total++;
        if ({pix_ce_a, obs_a} !== {1'b0, IDLE_A})
            $display("FAIL async_reset_a: got %h, required %h", {pix_ce_a, obs_a}, {1'b0, IDLE_A});
        else n_pass++;
        n_total++;
        if ({pix_ce_c, obs_c} !== {1'b0, IDLE_C})
            $display("FAIL async_reset_c: got %h, required %h", {pix_ce_c, obs_c}, {1'b0, IDLE_C});
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if ({pix_ce_a, obs_a} !== {1'b0, IDLE_A}) hold_err++;
            if ({pix_ce_c, obs_c} !== {1'b0, IDLE_C}) hold_err++;
        end
        n_total++;
        if (hold_err !== 0) $display("FAIL reset_hold_idle: got %0d active samples, required 0", hold_err);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        wait_ce_a(20, n);
        n_total++;
        if (n !== 4 || obs_a !== IDLE_A)
            $display("FAIL restart_first_ce_a: got %0d clks out %h, required 4 clks out %h", n, obs_a, IDLE_A);
        else n_pass++;
        wait_ce_a(20, n);
        n_total++;
        if (n !== 4 || obs_a !== exp_a(0, 0))
            $display("FAIL restart_origin_a: got %0d clks out %h, required 4 clks out %h", n, obs_a, exp_a(0, 0));
        else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        en_a  = 1'b0;
        en_b  = 1'b0;
        en_c  = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_startup_a();
        test_frame_a();
        test_en_drop_a();
        test_small_b();
        test_default_line_c();
        test_reset_midline();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
